// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge: each accepted AHB single becomes one APB SETUP/ACCESS pair.
// Optional feature macro AHBL_APB3_PSLVERR_EN: PSLVERR and watchdog expiry give a two-cycle AHB ERROR.
module ahbl_apb3_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

`ifdef AHBL_APB3_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CW-1:0]         wd_cnt;
    logic                  accept;
    logic                  timeout_hit;
    logic                  unused_inputs;

    assign accept        = HSEL & HREADY & HTRANS[1];
    assign unused_inputs = ^{HSIZE, HTRANS[0], HADDR[31:ADDR_WIDTH]};

    // The watchdog fires on the TIMEOUT-th stalled ACCESS cycle, so PSEL never outlives TIMEOUT ACCESS cycles.
    assign timeout_hit = (TIMEOUT > 0) && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'h0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= 32'h0;
            addr_q    <= '0;
            wd_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    state     <= ST_IDLE;
                    if (accept) begin
                        HREADYOUT <= 1'b0;
                        addr_q    <= HADDR[ADDR_WIDTH-1:0];
                        if (HWRITE) begin
                            state <= ST_WDATA;
                        end else begin
                            // Reads skip the data-capture cycle and go straight to SETUP.
                            state   <= ST_SETUP;
                            PSEL    <= 1'b1;
                            PENABLE <= 1'b0;
                            PWRITE  <= 1'b0;
                            PADDR   <= HADDR[ADDR_WIDTH-1:0];
                        end
                    end
                end
                ST_WDATA: begin
                    state   <= ST_SETUP;
                    PWDATA  <= HWDATA;
                    PSEL    <= 1'b1;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b1;
                    PADDR   <= addr_q;
                end
                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    PENABLE <= 1'b1;
                    wd_cnt  <= '0;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (!PWRITE) begin
                            HRDATA <= PRDATA;
                        end
                        if (ERR_EN && PSLVERR) begin
                            state <= ST_ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            HREADYOUT <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (!PWRITE) begin
                            HRDATA <= 32'h0;
                        end
                        if (ERR_EN) begin
                            state <= ST_ERR1;
                            HRESP <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            HREADYOUT <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_apb3_bridge.sv
// Scoreboard bench for ahbl_apb3_bridge: random AHB singles against an APB slave model with random waits.
// Honours AHBL_APB3_PSLVERR_EN the same way the design does.
`timescale 1ns/1ps
module tb_ahbl_apb3_bridge;

    localparam int ADDR_WIDTH = 12;
    localparam int TIMEOUT    = 6;
`ifdef AHBL_APB3_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    logic                  HCLK = 1'b0;
    logic                  HRESETN = 1'b1;
    logic                  HSEL = 1'b0;
    logic [31:0]           HADDR = 32'h0;
    logic [1:0]            HTRANS = T_IDLE;
    logic                  HWRITE = 1'b0;
    logic [2:0]            HSIZE = 3'b010;
    logic [31:0]           HWDATA = 32'h0;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic [31:0]           HRDATA;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [31:0]           PWDATA;
    logic [31:0]           PRDATA = 32'h0;
    logic                  PREADY = 1'b0;
    logic                  PSLVERR = 1'b0;

    assign HREADY = HREADYOUT;
    always #5 HCLK = ~HCLK;

    ahbl_apb3_bridge #(.ADDR_WIDTH(ADDR_WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          stalls;
        logic [31:0] prdata;
        logic        slverr;
        int          access;
    } apb_exp_t;

    typedef struct {
        int          len;
        int          resp_cycles;
        bit          check_rdata;
        logic [31:0] rdata;
    } ahb_exp_t;

    apb_exp_t    apb_q[$];
    ahb_exp_t    ahb_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_rdata = 32'h0;
    bit          model_known = 1'b1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: latency is the sum of the phases a transfer goes through, not a state walk.
    task automatic predict(input logic sel, input logic [1:0] trans, input logic write,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stalls,
                           input logic [31:0] prdata, input logic slverr);
        ahb_exp_t e;
        apb_exp_t a;
        bit       timed_out;
        bit       err;
        int       access;
        e.len = 1;
        e.resp_cycles = 0;
        if (sel && trans[1]) begin
            timed_out = (TIMEOUT > 0) && (stalls >= TIMEOUT);
            access    = timed_out ? TIMEOUT : stalls + 1;
            err       = ERR_EN && (timed_out || slverr);
            e.len     = (write ? 1 : 0) + 1 + access + 1 + (err ? 1 : 0);
            e.resp_cycles = err ? 2 : 0;
            if (!write) begin
                if (!timed_out) begin
                    model_rdata = prdata;
                    model_known = 1'b1;
                end else if (ERR_EN) begin
                    model_known = 1'b0;
                end else begin
                    model_rdata = 32'h0;
                    model_known = 1'b1;
                end
            end
            a.addr   = addr & ((32'h1 << ADDR_WIDTH) - 32'h1);
            a.write  = write;
            a.wdata  = wdata;
            a.stalls = stalls;
            a.prdata = prdata;
            a.slverr = slverr;
            a.access = access;
            apb_q.push_back(a);
        end
        e.check_rdata = model_known;
        e.rdata       = model_rdata;
        ahb_q.push_back(e);
    endtask

    // AHB master: holds the address phase until HREADY, then drives HWDATA for the data phase.
    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic write,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int stalls,
                                 input logic [31:0] prdata, input logic slverr);
        logic ready_now;
        int   guard;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = write;
        HADDR  = addr;
        HSIZE  = 3'($urandom_range(0, 2));
        guard  = 0;
        ready_now = 1'b0;
        forever begin
            ready_now = HREADYOUT;
            @(posedge HCLK);
            #1;
            if (ready_now) break;
            guard++;
            if (guard > 100) begin
                tests++;
                fails++;
                $display("[TB] FAIL accept_timeout: HREADYOUT low for %0d cycles, expected completion", guard);
                break;
            end
        end
        if (ready_now) predict(sel, trans, write, addr, wdata, stalls, prdata, slverr);
        HWDATA = (write && ready_now) ? wdata : $urandom;
    endtask

    // AHB monitor: measures each data phase and compares it with the scoreboard head.
    int       mon_cyc = 0;
    int       mon_resp = 0;
    ahb_exp_t mon_e;
    always @(negedge HCLK) begin
        if (!HRESETN) begin
            mon_cyc  = 0;
            mon_resp = 0;
        end else if (ahb_q.size() > 0) begin
            mon_cyc++;
            if (HRESP) mon_resp++;
            if (HREADYOUT) begin
                mon_e = ahb_q.pop_front();
                checkOutput("data_phase_len", mon_cyc, mon_e.len);
                checkOutput("hresp_cycles", mon_resp, mon_e.resp_cycles);
                if (mon_e.check_rdata) checkOutput("hrdata", HRDATA, mon_e.rdata);
                mon_cyc  = 0;
                mon_resp = 0;
            end else if (mon_cyc > 100) begin
                tests++;
                fails++;
                $display("[TB] FAIL data_phase_timeout: %0d cycles, expected %0d", mon_cyc, ahb_q[0].len);
                void'(ahb_q.pop_front());
                mon_cyc  = 0;
                mon_resp = 0;
            end
        end
    end

    // APB slave: checks each SETUP against the expected transfer and inserts the planned wait states.
    apb_exp_t cur;
    bit       have_cur = 1'b0;
    bit       in_acc = 1'b0;
    int       stall_left = 0;
    int       acc_cnt = 0;
    always @(negedge HCLK) begin
        if (!HRESETN) begin
            have_cur = 1'b0;
            in_acc   = 1'b0;
            acc_cnt  = 0;
            PREADY   = 1'b0;
        end else begin
            if (in_acc && !(PSEL && PENABLE)) begin
                checkOutput("access_cycles", acc_cnt, cur.access);
                in_acc   = 1'b0;
                have_cur = 1'b0;
            end
            if (PSEL && !PENABLE) begin
                if (apb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_setup: PADDR 0x%03h with no transfer pending", PADDR);
                end else if (!have_cur) begin
                    cur      = apb_q.pop_front();
                    have_cur = 1'b1;
                    checkOutput("paddr", PADDR, cur.addr);
                    checkOutput("pwrite", PWRITE, cur.write);
                    if (cur.write) checkOutput("pwdata", PWDATA, cur.wdata);
                    stall_left = cur.stalls;
                    acc_cnt    = 0;
                end
                PREADY  = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end else if (PSEL && PENABLE && have_cur) begin
                in_acc = 1'b1;
                acc_cnt++;
                if (stall_left == 0) begin
                    PREADY  = 1'b1;
                    PRDATA  = cur.prdata;
                    PSLVERR = cur.slverr;
                end else begin
                    stall_left--;
                    PREADY  = 1'b0;
                    PRDATA  = $urandom;
                    PSLVERR = 1'($urandom_range(0, 1));
                end
            end else begin
                PREADY  = 1'($urandom_range(0, 1));
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int g;
        #1 HRESETN = 1'b0;
        #2;
        checkOutput("rst_hreadyout", HREADYOUT, 1);
        checkOutput("rst_hresp", HRESP, 0);
        checkOutput("rst_hrdata", HRDATA, 0);
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        repeat (3) @(posedge HCLK);
        #1 HRESETN = 1'b1;
        @(posedge HCLK);
        #1;
        checkOutput("idle_hreadyout", HREADYOUT, 1);
        checkOutput("idle_psel", PSEL, 0);

        applyStimulus(1'b1, T_IDLE, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h0000_0ABC, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0000_0004, 32'h0, 5, 32'h12345678, 1'b0);
        applyStimulus(1'b1, T_BUSY, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0000_0008, 32'h0, 0, 32'hCAFEF00D, 1'b1);
        applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h0000_0010, 32'hA5A5_0010, 0, 32'h0, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0000_0014, 32'h0, 0, 32'h0BAD_0014, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0000_0020, 32'h0, TIMEOUT, 32'h5555_AAAA, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b1, 32'h0000_0024, 32'h1234_0024, TIMEOUT + 3, 32'h0, 1'b0);
        applyStimulus(1'b1, T_NSEQ, 1'b1, 32'hFFFF_F030, 32'h7777_0030, 1, 32'h0, 1'b1);

        for (int i = 0; i < 150; i++) begin
            logic       sel;
            logic [1:0] tr;
            int         r;
            int         st;
            sel = ($urandom_range(0, 9) != 0);
            r   = $urandom_range(0, 9);
            tr  = (r < 1) ? T_IDLE : (r < 2) ? T_BUSY : (r < 6) ? T_NSEQ : T_SEQ;
            r   = $urandom_range(0, 9);
            st  = (r < 6) ? $urandom_range(0, 2) : (r < 9) ? $urandom_range(3, TIMEOUT - 1)
                                                          : $urandom_range(TIMEOUT, TIMEOUT + 3);
            applyStimulus(sel, tr, 1'($urandom_range(0, 1)), $urandom, $urandom, st, $urandom,
                          ($urandom_range(0, 4) == 0));
        end

        // Abandon an APB read mid-ACCESS with an asynchronous reset.
        applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0000_0100, 32'h0, 3, 32'h0F0F_0F0F, 1'b0);
        HSEL   = 1'b0;
        HTRANS = T_IDLE;
        g = 0;
        while (!(PSEL && PENABLE) && g < 20) begin
            @(posedge HCLK);
            #1;
            g++;
        end
        checkOutput("reach_access", {31'h0, PSEL && PENABLE}, 1);
        #2 HRESETN = 1'b0;
        #1;
        checkOutput("async_psel", PSEL, 0);
        checkOutput("async_penable", PENABLE, 0);
        checkOutput("async_hreadyout", HREADYOUT, 1);
        checkOutput("async_hrdata", HRDATA, 0);
        ahb_q.delete();
        apb_q.delete();
        model_rdata = 32'h0;
        model_known = 1'b1;
        repeat (2) @(posedge HCLK);
        #1 HRESETN = 1'b1;
        @(posedge HCLK);
        #1;
        applyStimulus(1'b1, T_NSEQ, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h3C3C_0200, 1'b0);
        applyStimulus(1'b0, T_IDLE, 1'b0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
        HSEL   = 1'b0;
        HTRANS = T_IDLE;
        repeat (4) @(posedge HCLK);
        #1;
        checkOutput("ahb_queue_drained", ahb_q.size(), 0);
        checkOutput("apb_queue_drained", apb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
